// File: rtl/output_buffer_1x.sv
// output_buffer_1x: ping-pong reorder buffer for the M/2 synthesis path.
// Blocks of fft_size/2 samples are written in phase order and drained reversed.
module output_buffer_1x #(
    parameter int DATA_WIDTH    = 32,
    parameter int FFT_SIZE_BITS = 12
) (
    input  logic                     clk,
    input  logic                     sync_reset_n,
    input  logic                     s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tstart,
    output logic                     s_axis_tready,
    input  logic [FFT_SIZE_BITS-1:0] fft_size,
    output logic                     m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);
    localparam int AW    = FFT_SIZE_BITS - 1;
    localparam int DEPTH = 1 << AW;
    localparam int FD    = 4;

    typedef enum logic [1:0] {IDLE, READ0, READ1} rd_state_e;

    logic [DATA_WIDTH-1:0] mem_q [2*DEPTH];
    logic [DATA_WIDTH-1:0] rd1_q;
    logic [DATA_WIDTH-1:0] rd2_q;

    logic [AW-1:0]   len_q;
    logic [AW-1:0]   len_m1;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            wr_side_q, wr_side_d;
    logic [1:0]      full_q, full_d;
    rd_state_e       state_q, state_d;
    logic            rd_side_q, rd_side_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;

    logic            wr_hs;
    logic            resync;
    logic [AW-1:0]   wr_addr;
    logic            set_full;
    logic            clr_full;
    logic            lat_en;

    logic            act;
    logic            rd_bank;
    logic            credit;
    logic            issue;
    logic            rd_last;
    logic [AW-1:0]   rd_addr;

    logic            p1_v_q, p1_last_q;
    logic            p2_v_q, p2_last_q;

    logic [DATA_WIDTH-1:0] fd_q [FD];
    logic [DATA_WIDTH-1:0] fd_d [FD];
    logic                  fl_q [FD];
    logic                  fl_d [FD];
    logic [2:0]            cnt_q, cnt_d;
    logic                  vld_q;
    logic                  pop;
    logic                  push;

    assign len_m1        = len_q - AW'(1);
    assign s_axis_tready = ~full_q[wr_side_q];
    assign wr_hs         = s_axis_tvalid & s_axis_tready;
    assign resync        = s_axis_tstart & (wr_cnt_q != '0);
    assign wr_addr       = resync ? '0 : wr_cnt_q;

    // Illegal sizes (below 4) are never latched.
    assign lat_en = (full_q == 2'b00) && (wr_cnt_q == '0) &&
                    (state_q == IDLE) && (fft_size[1:0] == 2'b00) &&
                    (fft_size[FFT_SIZE_BITS-1:2] != '0);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_side_d = wr_side_q;
        set_full  = 1'b0;
        if (wr_hs) begin
            if (resync) begin
                wr_cnt_d = AW'(1);
            end else if (wr_cnt_q == len_m1) begin
                wr_cnt_d  = '0;
                wr_side_d = ~wr_side_q;
                set_full  = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end
    end

    // IDLE issues the first read itself so block turnaround costs no slot.
    always_comb begin
        act     = 1'b0;
        rd_bank = 1'b0;
        unique case (state_q)
            READ0: begin
                act     = 1'b1;
                rd_bank = 1'b0;
            end
            READ1: begin
                act     = 1'b1;
                rd_bank = 1'b1;
            end
            default: begin
                if (full_q[0] && rd_side_q) begin
                    act     = 1'b1;
                    rd_bank = 1'b0;
                end else if (full_q[1] && !rd_side_q) begin
                    act     = 1'b1;
                    rd_bank = 1'b1;
                end
            end
        endcase
    end

    assign credit  = (cnt_q + {2'b00, p1_v_q} + {2'b00, p2_v_q}) < 3'd4;
    assign issue   = act & credit;
    assign rd_last = (rd_cnt_q == len_m1);
    assign rd_addr = len_m1 - rd_cnt_q;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_side_d = rd_side_q;
        clr_full  = 1'b0;
        if (act) begin
            state_d = rd_bank ? READ1 : READ0;
        end
        if (issue) begin
            if (rd_last) begin
                rd_cnt_d  = '0;
                rd_side_d = rd_bank;
                clr_full  = 1'b1;
                state_d   = IDLE;
            end else begin
                rd_cnt_d = rd_cnt_q + AW'(1);
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d[wr_side_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    assign pop  = vld_q & m_axis_tready;
    assign push = p2_v_q;

    always_comb begin
        for (int i = 0; i < FD; i++) begin
            fd_d[i] = fd_q[i];
            fl_d[i] = fl_q[i];
        end
        cnt_d = cnt_q;
        if (pop) begin
            for (int i = 0; i < FD - 1; i++) begin
                fd_d[i] = fd_q[i+1];
                fl_d[i] = fl_q[i+1];
            end
            cnt_d = cnt_q - 3'd1;
        end
        if (push) begin
            fd_d[cnt_d[1:0]] = rd2_q;
            fl_d[cnt_d[1:0]] = p2_last_q;
            cnt_d            = cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem_q[{wr_side_q, wr_addr}] <= s_axis_tdata;
        end
        rd1_q <= mem_q[{rd_bank, rd_addr}];
        rd2_q <= rd1_q;
    end

    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            len_q     <= '0;
            wr_cnt_q  <= '0;
            wr_side_q <= 1'b0;
            full_q    <= '0;
            state_q   <= IDLE;
            rd_side_q <= 1'b1;
            rd_cnt_q  <= '0;
            p1_v_q    <= 1'b0;
            p1_last_q <= 1'b0;
            p2_v_q    <= 1'b0;
            p2_last_q <= 1'b0;
            cnt_q     <= '0;
            vld_q     <= 1'b0;
            for (int i = 0; i < FD; i++) begin
                fd_q[i] <= '0;
                fl_q[i] <= 1'b0;
            end
        end else begin
            if (lat_en) begin
                len_q <= fft_size[FFT_SIZE_BITS-1:1];
            end
            wr_cnt_q  <= wr_cnt_d;
            wr_side_q <= wr_side_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_side_q <= rd_side_d;
            rd_cnt_q  <= rd_cnt_d;
            p1_v_q    <= issue;
            p1_last_q <= issue & rd_last;
            p2_v_q    <= p1_v_q;
            p2_last_q <= p1_last_q;
            cnt_q     <= cnt_d;
            vld_q     <= (cnt_d != 3'd0);
            for (int i = 0; i < FD; i++) begin
                fd_q[i] <= fd_d[i];
                fl_q[i] <= fl_d[i];
            end
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = fd_q[0];
    assign m_axis_tlast  = fl_q[0];

endmodule

// File: tb/tb_output_buffer_1x.sv
// tb_output_buffer_1x: directed bench for output_buffer_1x.
// Outputs are gathered by a handshake monitor and compared to reversed blocks.
module tb_output_buffer_1x;
    logic        clk = 1'b0;
    logic        sync_reset_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tstart = 1'b0;
    logic        s_axis_tready;
    logic [11:0] fft_size = 12'd16;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int cyc = 0;
    logic [32:0] outq[$];
    int stamp[$];

    output_buffer_1x #(.DATA_WIDTH(32), .FFT_SIZE_BITS(12)) dut (
        .clk(clk),
        .sync_reset_n(sync_reset_n),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tstart(s_axis_tstart),
        .s_axis_tready(s_axis_tready),
        .fft_size(fft_size),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sync_reset_n && m_axis_tvalid && m_axis_tready) begin
            outq.push_back({m_axis_tlast, m_axis_tdata});
            stamp.push_back(cyc);
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic st);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tstart = st;
        while (!s_axis_tready && n < 300) begin
            step();
            n++;
            stalls++;
        end
        if (!s_axis_tready) chk("send_timeout", 64'(s_axis_tready), 64'd1);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tstart = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int n);
        int k;
        k = 0;
        while (outq.size() < n && k < 600) begin
            step();
            k++;
        end
        chk(tag, 64'(outq.size()), 64'(n));
    endtask

    task automatic chk_rev(input string tag, input int base, input int nblk,
                           input int len);
        for (int i = 0; i < nblk * len; i++) begin
            int e;
            logic [32:0] o;
            e = base + (i / len) * len + len - 1 - (i % len);
            o = (i < outq.size()) ? outq[i] : '1;
            chk($sformatf("%s_d%0d", tag, i), 64'(o[31:0]), 64'(e));
            chk($sformatf("%s_l%0d", tag, i), 64'(o[32]),
                64'((i % len) == len - 1));
        end
    endtask

    initial begin
        int gaps;
        int k;

        // reset values
        repeat (3) step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_sready", 64'(s_axis_tready), 64'd1);
        sync_reset_n = 1'b1;
        repeat (3) step();

        // single block, latency
        outq.delete();
        stamp.delete();
        for (int i = 0; i < 8; i++) send(32'(i), i == 0);
        chk("lat_t1", 64'(m_axis_tvalid), 64'd0);
        step();
        step();
        chk("lat_t3", 64'(m_axis_tvalid), 64'd0);
        step();
        chk("lat_t4", 64'(m_axis_tvalid), 64'd1);
        chk("lat_t4_data", 64'(m_axis_tdata), 64'd7);
        wait_out("single_cnt", 8);
        chk_rev("single", 0, 1, 8);

        // streaming
        outq.delete();
        stamp.delete();
        stalls = 0;
        for (int i = 0; i < 32; i++) send(32'(i), (i % 8) == 0);
        chk("stream_stalls", 64'(stalls), 64'd0);
        wait_out("stream_cnt", 32);
        chk_rev("stream", 0, 4, 8);
        gaps = 0;
        for (int i = 1; i < stamp.size(); i++)
            if (stamp[i] != stamp[i-1] + 1) gaps++;
        chk("stream_gaps", 64'(gaps), 64'd0);

        // backpressure
        repeat (5) step();
        outq.delete();
        stalls = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(32'(200 + i), (i % 8) == 0);
        chk("bp_stalls16", 64'(stalls), 64'd0);
        chk("bp_sready_low", 64'(s_axis_tready), 64'd0);
        chk("bp_mvalid", 64'(m_axis_tvalid), 64'd1);
        chk("bp_mdata", 64'(m_axis_tdata), 64'd207);
        repeat (5) step();
        chk("bp_sready_hold", 64'(s_axis_tready), 64'd0);
        chk("bp_mdata_hold", 64'(m_axis_tdata), 64'd207);
        chk("bp_mlast_hold", 64'(m_axis_tlast), 64'd0);
        m_axis_tready = 1'b1;
        for (int i = 16; i < 24; i++) send(32'(200 + i), (i % 8) == 0);
        wait_out("bp_cnt", 24);
        repeat (20) step();
        chk("bp_cnt_final", 64'(outq.size()), 64'd24);
        chk_rev("bp", 200, 3, 8);

        // resync
        outq.delete();
        send(32'd50, 1'b1);
        send(32'd51, 1'b0);
        send(32'd52, 1'b0);
        send(32'd100, 1'b1);
        for (int i = 101; i < 108; i++) send(32'(i), 1'b0);
        wait_out("resync_cnt", 8);
        repeat (20) step();
        chk("resync_cnt_final", 64'(outq.size()), 64'd8);
        chk_rev("resync", 100, 1, 8);

        // minimum size, then size change
        fft_size = 12'd4;
        repeat (3) step();
        outq.delete();
        send(32'd10, 1'b1);
        send(32'd11, 1'b0);
        wait_out("l2_cnt", 2);
        chk_rev("l2", 10, 1, 2);
        repeat (5) step();
        fft_size = 12'd8;
        repeat (3) step();
        outq.delete();
        send(32'd300, 1'b1);
        send(32'd301, 1'b0);
        fft_size = 12'd16;
        send(32'd302, 1'b0);
        send(32'd303, 1'b0);
        wait_out("l4_cnt", 4);
        chk_rev("l4", 300, 1, 4);
        repeat (10) step();

        // reset mid-read
        outq.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'(400 + i), i == 0);
        k = 0;
        while (!m_axis_tvalid && k < 50) begin
            step();
            k++;
        end
        chk("mr_pre_valid", 64'(m_axis_tvalid), 64'd1);
        #2;
        sync_reset_n = 1'b0;
        #1;
        chk("mr_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mr_tdata", 64'(m_axis_tdata), 64'd0);
        chk("mr_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mr_sready", 64'(s_axis_tready), 64'd1);
        step();
        step();
        sync_reset_n = 1'b1;
        m_axis_tready = 1'b1;
        outq.delete();
        repeat (2) step();
        for (int i = 0; i < 8; i++) send(32'(i), i == 0);
        wait_out("mr_cnt", 8);
        repeat (20) step();
        chk("mr_cnt_final", 64'(outq.size()), 64'd8);
        chk_rev("mr", 0, 1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/output_buffer_1x.md
# output_buffer_1x

Output reorder buffer for the M/2 polyphase synthesizer path; the counterpart of the channelizer input buffer. It accepts blocks of fft_size/2 samples in commutator (phase) order from the synthesis bank and writes them into a ping-pong RAM. Each completed block is read back in reversed order as a continuous AXI-Stream with a block marker. One bank fills while the other drains, so throughput is sustained at one sample per cycle.

## Interface
- DATA_WIDTH, 32, sample width (I/Q packed).
- FFT_SIZE_BITS, 12, width of fft_size; each RAM bank is 2^(FFT_SIZE_BITS-1) deep.
- clk  in  1  single clock; all logic on rising edge.
- sync_reset_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- s_axis_tstart  in  1  marks phase-0 sample of a block; qualified by handshake.
- s_axis_tready  out  1  high when the current write bank is not full.
- fft_size  in  FFT_SIZE_BITS  power of two, 4..2^(FFT_SIZE_BITS-1); block length L = fft_size/2.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tlast  out  1  last sample of a block.
- m_axis_tready  in  1  downstream accept.

## Operation
- Write side: wr_cnt counts 0..L-1. Each input handshake writes to bank wr_side at address wr_cnt.
- At wr_cnt==L-1: set full[wr_side], toggle wr_side, clear wr_cnt.
- s_axis_tready = ~full[wr_side].
- s_axis_tstart with wr_cnt!=0: discard the partial block. The sample is written at address 0 of the same bank, and wr_cnt becomes 1. tstart at wr_cnt==0 has no special effect.
- L is latched from fft_size only when both banks are empty, wr_cnt==0, and the read FSM is in IDLE. fft_size changes at any other time are ignored until that condition holds.
- Read FSM states: IDLE, READ0, READ1.
  - IDLE -> READ0 when full[0] and rd_side==1 (last bank read was 1). IDLE -> READ1 when full[1] and rd_side==0.
  - After reset, rd_side=1, so bank 0 is read first.
  - In READx, each cycle with read credit available: issue a read at address L-1-rd_cnt and increment rd_cnt.
  - On the issue with rd_cnt==L-1: clear full[x], tag the sample last, return to IDLE.
- Reset mid-operation clears all counters, full flags, the FSM, and the FIFO. RAM contents are not cleared and are not observed afterward.

## Timing
- RAM read latency: 2 cycles. Read data plus the last tag enter a 4-entry output FIFO with registered outputs.
- A read may issue only when FIFO occupancy plus in-flight reads is less than 4. The FIFO never overflows.
- Latency: the final write handshake of a block occurs at cycle t.
  - Bank full at t+1.
  - First read issues at t+1 if the FSM is in IDLE.
  - First m_axis_tvalid at t+4, with the FIFO empty and m_axis_tready high.
- With m_axis_tready held high and both banks alternating full, output is gap-free. The IDLE turnaround cycle is hidden by FIFO credit.
- A full-flag clear at cycle c makes s_axis_tready high at c+1 if that bank is the current write bank.
- A simultaneous block-complete write and read-complete on the same bank cannot occur: a bank is never written while full.
- Reset values (asynchronous): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. s_axis_tready=1, since both banks are empty.
- Output handshake follows AXI rules: m_axis_tdata and m_axis_tlast are held stable while tvalid is high and tready is low.

## Test plan
- Single block ordering: fft_size=16 (L=8), write 0..7 with tstart on 0.
  - Output is 7,6,5,4,3,2,1,0.
  - m_axis_tlast is high only on 0.
  - First tvalid arrives 4 cycles after the handshake of sample 7.
- Streaming: fft_size=16, 32 consecutive samples (0..31), tvalid and m_axis_tready held high.
  - Output is 7..0, 15..8, 23..16, 31..24, with no gaps after the first output sample.
  - s_axis_tready stays high.
- Backpressure: hold m_axis_tready low and feed 3 blocks of L=8.
  - s_axis_tready drops after the 16th sample.
  - After tready is released, all 24 samples emerge in correct reversed order with no loss or duplication.
- Resync: fft_size=16, assert tstart at wr_cnt==3 on value 100, then continue 101..107.
  - Output is 107..100.
  - The 3 samples written before the resync never appear.
- Minimum size and size change: run fft_size=4 (L=2) with samples A,B -> output B,A with last on A.
  - After draining, switch to fft_size=8; the next block of 4 is reversed correctly.
  - An fft_size change applied mid-block takes no effect.
- Reset mid-read: deassert sync_reset_n while m_axis_tvalid is high.
  - Outputs go to their reset values immediately and asynchronously.
  - After release, a fresh L=8 block 0..7 outputs 7..0, with bank 0 read first.
